// File: rtl/program_loader_pkg.sv
// Shared types for the program loader.
// Provides the controller state encoding and the 2-bit command opcodes.
// The opcode sits in the top two bits of a command word.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_COUNT,
    LOAD,
    CLEAR,
    RUN,
    HALTED,
    TIMEOUT
  } state_t;

  localparam logic [1:0] OP_LOAD_INSTR = 2'b00;
  localparam logic [1:0] OP_LOAD_DATA  = 2'b01;
  localparam logic [1:0] OP_START      = 2'b10;
  localparam logic [1:0] OP_NOP        = 2'b11;

endpackage

// File: rtl/loader_run_timer.sv
// Run cycle counter for the program loader.
// The counter saturates at all-ones. A timeout is flagged in the enabled
// cycle where the count equals MAX_RUN_CYCLES-1. Setting MAX_RUN_CYCLES to 0
// disables the timeout.
// Ports:
//   clk, clr  - clock and asynchronous active-high reset
//   clear     - synchronous clear of the count
//   en        - count this cycle
//   count     - cycles counted since the last clear
//   timeout   - terminal count reached in this enabled cycle
module loader_run_timer #(
  parameter int CYC_W          = 32,
  parameter int MAX_RUN_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clear,
  input  logic             en,
  output logic [CYC_W-1:0] count,
  output logic             timeout
);

  localparam logic [CYC_W-1:0] TERM_CNT = CYC_W'(MAX_RUN_CYCLES - 1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CYC_W'(1);
    end
  end

  assign timeout = (MAX_RUN_CYCLES != 0) && en && (count == TERM_CNT);

endmodule

// File: rtl/program_loader_ctrl.sv
// Program loader / run sequencer for the single-cycle RISC core.
// This block takes a 16-bit command and data stream using a valid/ready
// handshake. It writes the instruction and data memories, pulses the core
// clear, and then lets the core run. The run ends on done, on timeout or on
// abort.
// Ports:
//   clk, clr                   - clock, asynchronous active-high reset
//   in_valid/in_data/in_ready  - command and data stream
//   abort                      - aborts a run (ignored outside RUN)
//   cpu_done                   - core halted (level)
//   test_normal, cpu_clr       - memory ownership and core clear
//   ext_instr_* / ext_data_*   - memory write ports
//   busy, run_done, run_timeout, run_cycles - status
// Optional: when PROGRAM_LOADER_OUTR_CAPTURE_EN is defined, the block adds
// cpu_outr, last_outr and outr_changes. These capture changes of the core's
// output register during RUN.
//
// state     | meaning
// IDLE      | waiting for a command
// GET_ADDR  | next word is the load base address
// GET_COUNT | next word is the load word count
// LOAD      | each word is written to the selected memory
// CLEAR     | core held in clear, memories released
// RUN       | core running, cycles counted
// HALTED    | core finished normally
// TIMEOUT   | run exceeded MAX_RUN_CYCLES
module program_loader_ctrl
  import program_loader_pkg::*;
#(
  parameter int DATA_W           = 16,
  parameter int CYC_W            = 32,
  parameter int MAX_RUN_CYCLES   = 65536,
  parameter int CLR_PULSE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              abort,
  input  logic              cpu_done,
  output logic              test_normal,
  output logic              cpu_clr,
  output logic              ext_instr_we,
  output logic [DATA_W-1:0] ext_instr_addr,
  output logic [DATA_W-1:0] ext_instr_data,
  output logic              ext_data_we,
  output logic [DATA_W-1:0] ext_data_addr,
  output logic [DATA_W-1:0] ext_data_data,
  output logic              busy,
  output logic              run_done,
  output logic              run_timeout,
  output logic [CYC_W-1:0]  run_cycles
`ifdef PROGRAM_LOADER_OUTR_CAPTURE_EN
  ,
  input  logic [DATA_W-1:0] cpu_outr,
  output logic [DATA_W-1:0] last_outr,
  output logic [7:0]        outr_changes
`endif
);

  localparam int CLR_W = $clog2(CLR_PULSE_CYCLES + 1);

  state_t            state, state_nxt;
  logic              xfer;
  logic [1:0]        op;
  logic              sel_data;
  logic [DATA_W-1:0] cur_addr;
  logic [DATA_W-1:0] remain;
  logic [CLR_W-1:0]  clr_cnt;
  logic              run_tmo;

  assign xfer = in_valid && in_ready;
  assign op   = in_data[DATA_W-1 -: 2];

  loader_run_timer #(
    .CYC_W          (CYC_W),
    .MAX_RUN_CYCLES (MAX_RUN_CYCLES)
  ) u_timer (
    .clk     (clk),
    .clr     (clr),
    .clear   (state == CLEAR),
    .en      (state == RUN),
    .count   (run_cycles),
    .timeout (run_tmo)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b1;
    test_normal = 1'b1;
    cpu_clr     = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE, HALTED, TIMEOUT: begin
        busy = 1'b0;
        if (xfer) begin
          case (op)
            OP_LOAD_INSTR, OP_LOAD_DATA: state_nxt = GET_ADDR;
            OP_START:                    state_nxt = CLEAR;
            default:                     state_nxt = state;
          endcase
        end
      end
      GET_ADDR:  if (xfer) state_nxt = GET_COUNT;
      GET_COUNT: if (xfer) state_nxt = (in_data == '0) ? IDLE : LOAD;
      LOAD:      if (xfer && (remain == DATA_W'(1))) state_nxt = IDLE;
      CLEAR: begin
        in_ready    = 1'b0;
        test_normal = 1'b0;
        cpu_clr     = 1'b1;
        if (clr_cnt == '0) state_nxt = RUN;
      end
      RUN: begin
        in_ready    = 1'b0;
        test_normal = 1'b0;
        // abort > cpu_done > timeout
        if (abort)         state_nxt = IDLE;
        else if (cpu_done) state_nxt = HALTED;
        else if (run_tmo)  state_nxt = TIMEOUT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sel_data       <= 1'b0;
      cur_addr       <= '0;
      remain         <= '0;
      clr_cnt        <= '0;
      run_done       <= 1'b0;
      run_timeout    <= 1'b0;
      ext_instr_we   <= 1'b0;
      ext_instr_addr <= '0;
      ext_instr_data <= '0;
      ext_data_we    <= 1'b0;
      ext_data_addr  <= '0;
      ext_data_data  <= '0;
    end else begin
      ext_instr_we <= 1'b0;
      ext_data_we  <= 1'b0;
      case (state)
        IDLE, HALTED, TIMEOUT: begin
          if (xfer) begin
            run_done    <= 1'b0;
            run_timeout <= 1'b0;
            sel_data    <= (op == OP_LOAD_DATA);
            clr_cnt     <= CLR_W'(CLR_PULSE_CYCLES - 1);
          end
        end
        GET_ADDR:  if (xfer) cur_addr <= in_data;
        GET_COUNT: if (xfer) remain <= in_data;
        LOAD: begin
          if (xfer) begin
            if (sel_data) begin
              ext_data_we   <= 1'b1;
              ext_data_addr <= cur_addr;
              ext_data_data <= in_data;
            end else begin
              ext_instr_we   <= 1'b1;
              ext_instr_addr <= cur_addr;
              ext_instr_data <= in_data;
            end
            cur_addr <= cur_addr + DATA_W'(1);
            remain   <= remain - DATA_W'(1);
          end
        end
        CLEAR: if (clr_cnt != '0) clr_cnt <= clr_cnt - CLR_W'(1);
        RUN: begin
          if (!abort) begin
            if (cpu_done)     run_done    <= 1'b1;
            else if (run_tmo) run_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PROGRAM_LOADER_OUTR_CAPTURE_EN
  logic [DATA_W-1:0] prev_outr;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prev_outr    <= '0;
      last_outr    <= '0;
      outr_changes <= '0;
    end else begin
      prev_outr <= cpu_outr;
      if (state == CLEAR) begin
        last_outr    <= '0;
        outr_changes <= '0;
      end else if ((state == RUN) && (cpu_outr != prev_outr)) begin
        last_outr <= cpu_outr;
        if (outr_changes != 8'hFF) outr_changes <= outr_changes + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_program_loader_ctrl.sv
// Self-checking bench for program_loader_ctrl.
// dut uses the default parameters. dut_t uses MAX_RUN_CYCLES=16 and covers
// the timeout behaviour.
module tb_program_loader_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        abort = 1'b0;
  logic        cpu_done = 1'b0;
  logic        in_ready, test_normal, cpu_clr, ext_instr_we, ext_data_we;
  logic        busy, run_done, run_timeout;
  logic [15:0] ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data;
  logic [31:0] run_cycles;

  logic        t_in_valid = 1'b0;
  logic [15:0] t_in_data = '0;
  logic        t_cpu_done = 1'b0;
  logic        t_in_ready, t_test_normal, t_cpu_clr, t_ext_instr_we, t_ext_data_we;
  logic        t_busy, t_run_done, t_run_timeout;
  logic [15:0] t_ext_instr_addr, t_ext_instr_data, t_ext_data_addr, t_ext_data_data;
  logic [31:0] t_run_cycles;

  int tests = 0;
  int fails = 0;

  logic [31:0] instr_q[$];
  logic [31:0] data_q[$];
  logic [15:0] words_q[$];

  always #5 clk = ~clk;

  program_loader_ctrl dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .abort(abort), .cpu_done(cpu_done), .test_normal(test_normal), .cpu_clr(cpu_clr),
    .ext_instr_we(ext_instr_we), .ext_instr_addr(ext_instr_addr), .ext_instr_data(ext_instr_data),
    .ext_data_we(ext_data_we), .ext_data_addr(ext_data_addr), .ext_data_data(ext_data_data),
    .busy(busy), .run_done(run_done), .run_timeout(run_timeout), .run_cycles(run_cycles)
`ifdef PROGRAM_LOADER_OUTR_CAPTURE_EN
    , .cpu_outr(16'h0), .last_outr(), .outr_changes()
`endif
  );

  program_loader_ctrl #(.MAX_RUN_CYCLES(16)) dut_t (
    .clk(clk), .clr(clr), .in_valid(t_in_valid), .in_data(t_in_data), .in_ready(t_in_ready),
    .abort(1'b0), .cpu_done(t_cpu_done), .test_normal(t_test_normal), .cpu_clr(t_cpu_clr),
    .ext_instr_we(t_ext_instr_we), .ext_instr_addr(t_ext_instr_addr), .ext_instr_data(t_ext_instr_data),
    .ext_data_we(t_ext_data_we), .ext_data_addr(t_ext_data_addr), .ext_data_data(t_ext_data_data),
    .busy(t_busy), .run_done(t_run_done), .run_timeout(t_run_timeout), .run_cycles(t_run_cycles)
`ifdef PROGRAM_LOADER_OUTR_CAPTURE_EN
    , .cpu_outr(16'h0), .last_outr(), .outr_changes()
`endif
  );

  // Record every memory write strobe as {addr, data}.
  always @(negedge clk) begin
    if (ext_instr_we) instr_q.push_back({ext_instr_addr, ext_instr_data});
    if (ext_data_we)  data_q.push_back({ext_data_addr, ext_data_data});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word at a negedge and return at the negedge after it is taken.
  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Load the words in words_q. The expected writes are base+i (mod 2^16)
  // paired with word i, on the memory chosen by cmd.
  task automatic do_load(input logic [15:0] cmd, input logic [15:0] base);
    logic [31:0] exp_q[$];
    logic [31:0] got;
    bit          is_data;
    is_data = (cmd[15:14] == 2'b01);
    instr_q.delete();
    data_q.delete();
    foreach (words_q[i]) exp_q.push_back({16'(base + 16'(i)), words_q[i]});
    send(cmd);
    send(base);
    send(16'(words_q.size()));
    foreach (words_q[i]) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(words_q[i]);
    end
    repeat (2) @(negedge clk);
    check("load_count", is_data ? data_q.size() : instr_q.size(), exp_q.size());
    check("load_other_mem", is_data ? instr_q.size() : data_q.size(), 0);
    foreach (exp_q[i]) begin
      if (is_data) got = (i < data_q.size()) ? data_q[i] : 'x;
      else         got = (i < instr_q.size()) ? instr_q[i] : 'x;
      check("load_write", got, exp_q[i]);
    end
    check("load_idle_busy", busy, 0);
    check("load_idle_ready", in_ready, 1);
  endtask

  // Issue START and return at the negedge of the first RUN cycle.
  task automatic start_run();
    int n;
    send({2'b10, 14'($urandom)});
    check("clear_test_normal", test_normal, 0);
    check("clear_ready", in_ready, 0);
    n = 0;
    while (cpu_clr && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("clear_len", n, 2);
    check("run_entry_cycles", run_cycles, 0);
    check("run_test_normal", test_normal, 0);
  endtask

  // cpu_done is first seen in the d-th RUN cycle, so the run lasts d cycles.
  task automatic run_done_after(input int d);
    start_run();
    repeat (d - 1) @(negedge clk);
    cpu_done = 1'b1;
    @(negedge clk);
    cpu_done = 1'b0;
    check("done_flag", run_done, 1);
    check("done_timeout_flag", run_timeout, 0);
    check("done_cycles", run_cycles, d);
    check("done_test_normal", test_normal, 1);
    check("done_busy", busy, 0);
  endtask

  initial begin
    int          n;
    int          k;
    logic [15:0] base;

    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_test_normal", test_normal, 1);
    check("rst_outs", {cpu_clr, ext_instr_we, ext_data_we, busy, run_done, run_timeout}, 0);
    check("rst_buses", {ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data}, 0);
    check("rst_cycles", run_cycles, 0);
    clr = 1'b0;
    @(negedge clk);

    words_q = '{16'hE000, 16'h140A};
    do_load(16'h0000, 16'h0000);
    words_q = '{16'h0012, 16'h0034};
    do_load(16'h4000, 16'hFFFF);

    // abort outside RUN must not disturb a load
    abort = 1'b1;
    words_q = '{16'h1111, 16'h2222, 16'h3333};
    do_load(16'h0000 | 16'($urandom_range(0, 16'h3FFF)), 16'($urandom));
    abort = 1'b0;

    for (int r = 0; r < 6; r++) begin
      words_q.delete();
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
      do_load({1'b0, 1'($urandom), 14'($urandom)}, 16'($urandom_range(16'hFFF8, 16'hFFFF) - 16'($urandom_range(0, 1) * 16'h8000)));
    end

    run_done_after(25);
    send({2'b11, 14'($urandom)});
    check("nop_clears_done", run_done, 0);
    check("nop_busy", busy, 0);
    check("nop_test_normal", test_normal, 1);
    check("nop_cycles_held", run_cycles, 25);

    for (int r = 0; r < 4; r++) run_done_after($urandom_range(1, 40));

    // cpu_done held during CLEAR is not acted on until RUN
    cpu_done = 1'b1;
    start_run();
    @(negedge clk);
    cpu_done = 1'b0;
    check("early_done_flag", run_done, 1);
    check("early_done_cycles", run_cycles, 1);

    k = $urandom_range(0, 10);
    start_run();
    repeat (k) @(negedge clk);
    abort    = 1'b1;
    cpu_done = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    cpu_done = 1'b0;
    check("abort_flags", {run_done, run_timeout}, 0);
    check("abort_busy", busy, 0);
    check("abort_test_normal", test_normal, 1);
    check("abort_cycles", run_cycles, k + 1);

    words_q.delete();
    do_load(16'h0000, 16'h0123);

    t_in_data  = 16'h8000;
    t_in_valid = 1'b1;
    @(negedge clk);
    t_in_valid = 1'b0;
    n = 0;
    while (t_cpu_clr && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("t_clear_len", n, 2);
    n = 0;
    while (!t_run_timeout && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("t_timeout_latency", n, 16);
    check("t_timeout_cycles", t_run_cycles, 16);
    check("t_timeout_status", {t_test_normal, t_in_ready, t_busy, t_run_done}, 4'b1100);
    check("t_no_writes", {t_ext_instr_we, t_ext_data_we, t_ext_instr_addr, t_ext_data_addr,
                          t_ext_instr_data, t_ext_data_data}, 0);

    // cpu_done in the same cycle as the timeout wins
    t_in_data  = 16'h8000;
    t_in_valid = 1'b1;
    @(negedge clk);
    t_in_valid = 1'b0;
    n = 0;
    while (t_cpu_clr && n < 20) begin
      n++;
      @(negedge clk);
    end
    repeat (15) @(negedge clk);
    t_cpu_done = 1'b1;
    @(negedge clk);
    t_cpu_done = 1'b0;
    check("t_done_over_timeout", {t_run_done, t_run_timeout}, 2'b10);
    check("t_done_cycles", t_run_cycles, 16);

    words_q.delete();
    for (int i = 0; i < 10; i++) words_q.push_back(16'($urandom));
    base = 16'h1230 | 16'($urandom_range(1, 15));
    send(16'h0000);
    send(base);
    send(16'd10);
    for (int i = 0; i < 3; i++) send(words_q[i]);
    #1 clr = 1'b1;
    #1;
    check("clr_ready", in_ready, 1);
    check("clr_test_normal", test_normal, 1);
    check("clr_outs", {cpu_clr, ext_instr_we, ext_data_we, busy, run_done, run_timeout}, 0);
    check("clr_buses", {ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data}, 0);
    check("clr_cycles", run_cycles, 0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    do_load(16'h0000, base);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
